// File: rtl/motor_cmd_ramp.sv
// Slew-limited command front end for the motor PWM generator.
// Ports: clk, rst (async high); cmd_valid/cmd_ready/cmd_en/cmd_dir/cmd_spd
// host command; estop; en/dir/spd_sel to PWM; at_target, wdog_trip status.
module motor_cmd_ramp #(
    parameter int RAMP_DIV = 1000,
    parameter int STEP     = 5,
    parameter int DWELL    = 2000,
    parameter int WDOG     = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_en,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_spd,
    input  logic       estop,
    output logic       en,
    output logic       dir,
    output logic [7:0] spd_sel,
    output logic       at_target,
    output logic       wdog_trip
);

    localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int WW = (WDOG > 0) ? $clog2(WDOG + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [WW-1:0] WDOG_LIM   = WW'(WDOG);
    localparam logic [8:0]    STEP9      = 9'(STEP);
    localparam bit            WD_ON      = (WDOG != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DWELL
    } state_t;

    state_t        st, st_n;
    logic [7:0]    tgt_spd, tgt_spd_n;
    logic          tgt_dir, tgt_dir_n;
    logic          tgt_en, tgt_en_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [DW-1:0] dwell_cnt, dwell_n;
    logic [WW-1:0] wdog_cnt, wdog_n;
    logic          trip_n, dir_n, en_n, at_n, wd_bite;
    logic [7:0]    spd_n, ramp;
    logic [8:0]    sum9, diff9;
    logic          accept, tick, rev, up, dn;

    assign cmd_ready = !estop;
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (tick_cnt == TICK_LAST);

    // 9-bit arithmetic: bit 8 of diff9 flags an underflow below zero,
    // sum9 can exceed 255 and is clamped by the target compare.
    assign sum9  = {1'b0, spd_sel} + STEP9;
    assign diff9 = {1'b0, spd_sel} - STEP9;
    assign rev   = (tgt_dir != dir);
    assign up    = !rev && (spd_sel < tgt_spd);
    assign dn    = !rev && (spd_sel > tgt_spd);

    always_comb begin
        ramp = spd_sel;
        unique case (1'b1)
            rev: ramp = diff9[8] ? 8'd0 : diff9[7:0];
            up:  ramp = (sum9 > {1'b0, tgt_spd}) ? tgt_spd : sum9[7:0];
            dn:  ramp = (diff9[8] || (diff9[7:0] < tgt_spd))
                        ? tgt_spd : diff9[7:0];
            default: ramp = spd_sel;
        endcase
    end

    always_comb begin
        st_n      = st;
        dir_n     = dir;
        spd_n     = spd_sel;
        tgt_spd_n = tgt_spd;
        tgt_dir_n = tgt_dir;
        tgt_en_n  = tgt_en;
        tick_n    = tick_cnt;
        dwell_n   = dwell_cnt;
        wdog_n    = wdog_cnt;
        trip_n    = wdog_trip;
        wd_bite   = 1'b0;
        if (estop) begin
            st_n      = S_IDLE;
            spd_n     = 8'd0;
            tgt_spd_n = 8'd0;
            tgt_en_n  = 1'b0;
        end else begin
            // Saturating count so a tripped watchdog fires only once.
            if (WD_ON && st != S_IDLE && wdog_cnt != WDOG_LIM) begin
                wdog_n  = wdog_cnt + 1'b1;
                wd_bite = (wdog_n == WDOG_LIM);
            end
            if (accept) begin
                tgt_en_n  = cmd_en;
                tgt_dir_n = cmd_dir;
                tgt_spd_n = cmd_en ? cmd_spd : 8'd0;
                wdog_n    = '0;
                trip_n    = 1'b0;
            end else if (wd_bite) begin
                trip_n    = 1'b1;
                tgt_en_n  = 1'b0;
                tgt_spd_n = 8'd0;
            end
            // Transitions use the registered target, so a command
            // landing on a tick only affects the following tick.
            unique case (st)
                S_IDLE: begin
                    if (accept && cmd_en) begin
                        st_n   = S_RUN;
                        dir_n  = cmd_dir;
                        tick_n = '0;
                    end
                end
                S_RUN: begin
                    if (spd_sel == 8'd0 && rev) begin
                        st_n    = S_DWELL;
                        dwell_n = '0;
                    end else if (spd_sel == 8'd0 && !tgt_en) begin
                        st_n = S_IDLE;
                    end else begin
                        tick_n = tick ? '0 : tick_cnt + 1'b1;
                        if (tick) spd_n = ramp;
                    end
                end
                S_DWELL: begin
                    if (!tgt_en) begin
                        st_n = S_IDLE;
                    end else if (!rev) begin
                        st_n   = S_RUN;
                        tick_n = '0;
                    end else if (dwell_cnt == DWELL_LAST) begin
                        st_n   = S_RUN;
                        dir_n  = tgt_dir;
                        tick_n = '0;
                    end else begin
                        dwell_n = dwell_cnt + 1'b1;
                    end
                end
                default: st_n = S_IDLE;
            endcase
        end
        en_n = (st_n != S_IDLE);
        at_n = (st_n == S_IDLE) ||
               (st_n == S_RUN && spd_n == tgt_spd_n && dir_n == tgt_dir_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            tgt_spd   <= 8'd0;
            tgt_dir   <= 1'b0;
            tgt_en    <= 1'b0;
            tick_cnt  <= '0;
            dwell_cnt <= '0;
            wdog_cnt  <= '0;
            en        <= 1'b0;
            dir       <= 1'b0;
            spd_sel   <= 8'd0;
            at_target <= 1'b1;
            wdog_trip <= 1'b0;
        end else begin
            st        <= st_n;
            tgt_spd   <= tgt_spd_n;
            tgt_dir   <= tgt_dir_n;
            tgt_en    <= tgt_en_n;
            tick_cnt  <= tick_n;
            dwell_cnt <= dwell_n;
            wdog_cnt  <= wdog_n;
            en        <= en_n;
            dir       <= dir_n;
            spd_sel   <= spd_n;
            at_target <= at_n;
            wdog_trip <= trip_n;
        end
    end

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Bench for motor_cmd_ramp: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the ramp.
module tb_motor_cmd_ramp;

    localparam int RD = 4;
    localparam int ST = 5;
    localparam int DW = 8;
    localparam int WD = 64;

    localparam int OFF   = 0;
    localparam int DRIVE = 1;
    localparam int PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_en = 1'b0;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_spd = 8'd0;
    logic       estop = 1'b0;
    logic       cmd_ready, en, dir, at_target, wdog_trip;
    logic [7:0] spd_sel;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    motor_cmd_ramp #(
        .RAMP_DIV(RD),
        .STEP(ST),
        .DWELL(DW),
        .WDOG(WD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_en(cmd_en),
        .cmd_dir(cmd_dir),
        .cmd_spd(cmd_spd),
        .estop(estop),
        .en(en),
        .dir(dir),
        .spd_sel(spd_sel),
        .at_target(at_target),
        .wdog_trip(wdog_trip)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase, age = cycles since entering the phase,
    // quiet = active cycles since the last accepted command.
    typedef struct {
        int ph;
        int spd;
        int dir;
        int age;
        int quiet;
        int trip;
        int gen;
        int gdir;
        int gspd;
    } mstate_t;

    mstate_t m;

    function automatic int toward(input int cur, input int goal,
                                  input bit reverse);
        if (reverse) return (cur > ST) ? cur - ST : 0;
        if (cur < goal) return (cur + ST < goal) ? cur + ST : goal;
        if (cur > goal) return (cur - ST > goal) ? cur - ST : goal;
        return cur;
    endfunction

    function automatic mstate_t model_next(input mstate_t c, input bit v,
                                           input bit ce, input bit cd,
                                           input int cs, input bit es);
        mstate_t n;
        bit bite;
        n = c;
        bite = 1'b0;
        if (es) begin
            n.ph = OFF;
            n.spd = 0;
            n.gen = 0;
            n.gspd = 0;
            return n;
        end
        if (WD != 0 && c.ph != OFF && c.quiet < WD) begin
            n.quiet = c.quiet + 1;
            bite = (n.quiet == WD);
        end
        if (v) begin
            n.gen = ce;
            n.gdir = cd;
            n.gspd = ce ? cs : 0;
            n.quiet = 0;
            n.trip = 0;
        end else if (bite) begin
            n.trip = 1;
            n.gen = 0;
            n.gspd = 0;
        end
        case (c.ph)
            OFF: if (v && ce) begin
                n.ph = DRIVE;
                n.dir = cd;
                n.age = 0;
            end
            DRIVE: begin
                if (c.spd == 0 && c.gdir != c.dir) begin
                    n.ph = PAUSE;
                    n.age = 0;
                end else if (c.spd == 0 && c.gen == 0) begin
                    n.ph = OFF;
                end else begin
                    if (c.age % RD == RD - 1)
                        n.spd = toward(c.spd, c.gspd, c.gdir != c.dir);
                    n.age = c.age + 1;
                end
            end
            PAUSE: begin
                if (c.gen == 0) begin
                    n.ph = OFF;
                end else if (c.gdir == c.dir) begin
                    n.ph = DRIVE;
                    n.age = 0;
                end else if (c.age == DW - 1) begin
                    n.ph = DRIVE;
                    n.dir = c.gdir;
                    n.age = 0;
                end else begin
                    n.age = c.age + 1;
                end
            end
            default: n.ph = OFF;
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{default: 0};
        else m <= model_next(m, cmd_valid, cmd_en, cmd_dir,
                             int'(cmd_spd), estop);
    end

    always @(negedge clk) begin
        chk("model_en", int'(en), int'(m.ph != OFF));
        chk("model_dir", int'(dir), m.dir);
        chk("model_spd", int'(spd_sel), m.spd);
        chk("model_at", int'(at_target),
            int'(m.ph == OFF ||
                 (m.ph == DRIVE && m.spd == m.gspd && m.dir == m.gdir)));
        chk("model_trip", int'(wdog_trip), m.trip);
        chk("model_ready", int'(cmd_ready), int'(!estop));
    end

    task automatic adv(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit e, input bit d, input int s);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_en = e;
        cmd_dir = d;
        cmd_spd = 8'(s);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic expect_next(input string name, input int v,
                               input int budget);
        logic [7:0] s0;
        int k;
        s0 = spd_sel;
        k = 0;
        while (spd_sel == s0 && k < budget) begin
            adv(1);
            k++;
        end
        chk(name, int'(spd_sel), v);
    endtask

    initial begin
        int k;
        int prev;
        int r;
        bit en_ok;

        // reset
        rst = 1'b1;
        adv(3);
        rst = 1'b0;
        adv(2);
        chk("rst_en", int'(en), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_spd", int'(spd_sel), 0);
        chk("rst_at", int'(at_target), 1);
        chk("rst_trip", int'(wdog_trip), 0);

        // ramp up to 12
        send(1'b1, 1'b0, 12);
        chk("up_en", int'(en), 1);
        chk("up_at0", int'(at_target), 0);
        adv(3);
        chk("up_hold", int'(spd_sel), 0);
        adv(1);
        chk("up_5", int'(spd_sel), 5);
        adv(4);
        chk("up_10", int'(spd_sel), 10);
        adv(4);
        chk("up_12", int'(spd_sel), 12);
        chk("up_at1", int'(at_target), 1);

        // reversal to dir 1, speed 10
        send(1'b1, 1'b1, 10);
        expect_next("rev_7", 7, 8);
        expect_next("rev_2", 2, 8);
        expect_next("rev_0", 0, 8);
        k = 0;
        en_ok = 1'b1;
        while (dir == 1'b0 && k < 20) begin
            adv(1);
            k++;
            if (!en) en_ok = 1'b0;
        end
        chk("rev_dwell_edges", k, 9);
        chk("rev_dwell_en", int'(en_ok), 1);
        adv(3);
        chk("rev_hold", int'(spd_sel), 0);
        adv(1);
        chk("rev_5", int'(spd_sel), 5);
        adv(4);
        chk("rev_10", int'(spd_sel), 10);

        // estop mid-ramp at speed 10
        send(1'b1, 1'b1, 30);
        estop = 1'b1;
        cmd_valid = 1'b1;
        cmd_en = 1'b1;
        cmd_spd = 8'd50;
        #1;
        chk("estop_ready", int'(cmd_ready), 0);
        adv(1);
        chk("estop_en", int'(en), 0);
        chk("estop_spd", int'(spd_sel), 0);
        adv(3);
        chk("estop_hold_en", int'(en), 0);
        estop = 1'b0;
        cmd_valid = 1'b0;
        adv(2);
        chk("estop_ignored", int'(en), 0);
        chk("estop_at", int'(at_target), 1);

        // watchdog
        send(1'b1, 1'b0, 12);
        k = 0;
        while (!wdog_trip && k < 100) begin
            adv(1);
            k++;
        end
        chk("wdog_edges", k, 64);
        expect_next("wdog_7", 7, 8);
        expect_next("wdog_2", 2, 8);
        expect_next("wdog_0", 0, 8);
        adv(1);
        chk("wdog_idle", int'(en), 0);
        chk("wdog_sticky", int'(wdog_trip), 1);
        send(1'b1, 1'b0, 20);
        chk("wdog_clear", int'(wdog_trip), 0);

        // full-scale ramp, refreshed against the watchdog
        send(1'b1, 1'b0, 255);
        prev = int'(spd_sel);
        k = 0;
        while (spd_sel != 8'd255 && k < 400) begin
            cmd_valid = (k % 32 == 0);
            adv(1);
            k++;
            if (int'(spd_sel) != prev) begin
                chk("ramp255_step", int'(spd_sel),
                    (prev + ST > 255) ? 255 : prev + ST);
                prev = int'(spd_sel);
            end
        end
        cmd_valid = 1'b0;
        chk("ramp255_top", int'(spd_sel), 255);
        adv(8);
        chk("ramp255_hold", int'(spd_sel), 255);

        // reset mid-run drops straight to reset values
        rst = 1'b1;
        #1;
        chk("rst_mid_spd", int'(spd_sel), 0);
        chk("rst_mid_en", int'(en), 0);
        chk("rst_mid_at", int'(at_target), 1);
        adv(2);
        rst = 1'b0;

        // disable from speed 3
        send(1'b1, 1'b0, 3);
        expect_next("low_3", 3, 8);
        send(1'b0, 1'b0, 0);
        expect_next("low_0", 0, 8);
        chk("low_en_run", int'(en), 1);
        adv(1);
        chk("low_idle", int'(en), 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (i % 1000 >= 800) cmd_valid = ($urandom_range(0, 99) == 0);
            else cmd_valid = ($urandom_range(0, 9) == 0);
            cmd_en = ($urandom_range(0, 5) != 0);
            cmd_dir = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r == 0) cmd_spd = 8'd255;
            else if (r == 1) cmd_spd = 8'd0;
            else cmd_spd = 8'($urandom_range(0, 255));
            if (estop) estop = ($urandom_range(0, 2) != 0);
            else estop = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 2999) == 0);
        end
        cmd_valid = 1'b0;
        estop = 1'b0;
        rst = 1'b0;
        adv(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
